// File: rtl/mac_result_drain_pkg.sv
// Shared constants, mode encoding and word-count helper for the MAC result drain.
package mac_result_drain_pkg;

    localparam int MAC_ACC_WIDTH       = 32;
    localparam int MAC_DRAIN_OUT_WIDTH = 16;

    // Cluster mode encoding, identical to the combiner's cfg[1:0].
    typedef enum logic [1:0] {
        MAC_MODE_SINGLE = 2'b00,
        MAC_MODE_DUAL   = 2'b01,
        MAC_MODE_QUAD   = 2'b10,
        MAC_MODE_RSVD   = 2'b11
    } mac_mode_e;

    // Index of the final active word for a mode; reserved behaves as single.
    function automatic logic [1:0] mac_last_word(input logic [1:0] mode);
        case (mac_mode_e'(mode))
            MAC_MODE_DUAL: return 2'd1;
            MAC_MODE_QUAD: return 2'd0;
            default:       return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mac_result_drain_if.sv
// Narrow valid/ready stream carrying serialized cluster results.
interface mac_result_drain_if
    import mac_result_drain_pkg::*;
#(
    parameter int OUT_WIDTH = MAC_DRAIN_OUT_WIDTH
) ();

    logic [OUT_WIDTH-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/mac_drain_slicer.sv
// Combinational selector: snapshot word[word_i] slice[beat_i] onto the output bus.
module mac_drain_slicer
    import mac_result_drain_pkg::*;
#(
    parameter int ACC_WIDTH = MAC_ACC_WIDTH,
    parameter int OUT_WIDTH = MAC_DRAIN_OUT_WIDTH,
    parameter int BEAT_W    = 1
) (
    input  logic [4*ACC_WIDTH-1:0] snap_i,
    input  logic [1:0]             word_i,
    input  logic [BEAT_W-1:0]      beat_i,
    output logic [OUT_WIDTH-1:0]   slice_o
);

    localparam int BPW   = ACC_WIDTH / OUT_WIDTH;
    localparam int NSL   = 4 * BPW;
    localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;

    // Slices laid out word-major, LSB slice first, so the flat index is word*BPW+beat.
    logic [OUT_WIDTH-1:0] slices [NSL];
    logic [IDX_W-1:0]     idx;

    for (genvar i = 0; i < NSL; i++) begin : g_slice
        assign slices[i] = snap_i[i*OUT_WIDTH +: OUT_WIDTH];
    end

    // Flat slice index from the word and beat counters.
    always_comb begin
        idx     = IDX_W'(word_i) * IDX_W'(BPW) + IDX_W'(beat_i);
        slice_o = slices[idx];
    end

endmodule

// File: rtl/mac_result_drain.sv
// Snapshots the cluster's active result words on capture and streams them out
// one OUT_WIDTH beat at a time, word 0 first, least-significant slice first.
module mac_result_drain
    import mac_result_drain_pkg::*;
#(
    parameter int ACC_WIDTH = MAC_ACC_WIDTH,
    parameter int OUT_WIDTH = MAC_DRAIN_OUT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode_i,
    input  logic                 capture_i,
    input  logic [ACC_WIDTH-1:0] out0_i,
    input  logic [ACC_WIDTH-1:0] out1_i,
    input  logic [ACC_WIDTH-1:0] out2_i,
    input  logic [ACC_WIDTH-1:0] out3_i,
    mac_result_drain_if.master   tx,
    output logic                 busy_o,
    output logic                 overrun_o,
    input  logic                 clr_overrun_i
);

    localparam int BPW    = ACC_WIDTH / OUT_WIDTH;
    localparam int BEAT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BPW - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    if ((ACC_WIDTH % OUT_WIDTH) != 0 || ACC_WIDTH < OUT_WIDTH) begin : g_bad_width
        $error("mac_result_drain: ACC_WIDTH must be an integer multiple of OUT_WIDTH");
    end

    logic [0:0]             state_q, state_d;
    logic [4*ACC_WIDTH-1:0] snap_q, snap_d;
    logic [1:0]             last_word_q, last_word_d;
    logic [1:0]             word_q, word_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic                   overrun_q, overrun_d;

    logic                 sending;
    logic                 xfer;
    logic                 last_beat;
    logic                 load;
    logic                 drop;
    logic [OUT_WIDTH-1:0] slice;

    assign sending   = (state_q == SEND);
    assign xfer      = sending && tx.ready;
    assign last_beat = (word_q == last_word_q) && (beat_q == BEAT_LAST);
    // A capture is honoured when idle or exactly on the last-beat transfer (no bubble).
    assign load      = capture_i && (!sending || (xfer && last_beat));
    assign drop      = capture_i && sending && !(xfer && last_beat);

    mac_drain_slicer #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .BEAT_W    (BEAT_W)
    ) u_slicer (
        .snap_i  (snap_q),
        .word_i  (word_q),
        .beat_i  (beat_q),
        .slice_o (slice)
    );

    assign tx.valid  = sending;
    assign tx.last   = sending && last_beat;
    assign tx.data   = sending ? slice : '0;
    assign busy_o    = sending;
    assign overrun_o = overrun_q;

    // Next-state logic for the FSM, counters, snapshot and overrun flag.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        snap_d      = snap_q;
        last_word_d = last_word_q;
        word_d      = word_q;
        beat_d      = beat_q;
        overrun_d   = overrun_q;

        if (xfer) begin
            if (last_beat) begin
                state_d = IDLE;
                word_d  = '0;
                beat_d  = '0;
            end else if (beat_q == BEAT_LAST) begin
                word_d = word_q + 2'd1;
                beat_d = '0;
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end

        if (load) begin
            state_d     = SEND;
            snap_d      = {out3_i, out2_i, out1_i, out0_i};
            last_word_d = mac_last_word(mode_i);
            word_d      = '0;
            beat_d      = '0;
        end

        // A dropped capture wins over a simultaneous clear.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end
    end

    // State registers with synchronous reset taking priority over all inputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            // NOTE: the snapshot is reset too, so no stale result survives a reset.
            snap_q      <= '0;
            last_word_q <= '0;
            word_q      <= '0;
            beat_q      <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            last_word_q <= last_word_d;
            word_q      <= word_d;
            beat_q      <= beat_d;
            overrun_q   <= overrun_d;
        end
    end

endmodule

// File: doc/mac_result_drain.md
Name: mac_result_drain

Overview:
- Reads the four accumulator outputs (out0..out3) of a MAC quad-cluster and streams them out over a narrow valid/ready bus.
- On a capture pulse it snapshots the active results; the number of active words is selected by the cluster's Single/Dual/Quad mode bits.
- It then serializes the snapshot beat by beat to the fabric or readout path.
- It sits directly downstream of the cluster and is the consumer end of the cluster's result interface.

Parameters:
- ACC_WIDTH, default `MAC_ACC_WIDTH: width of each cluster result word.
- OUT_WIDTH, default 16: width of the serialized output bus. ACC_WIDTH must be an integer multiple of OUT_WIDTH; elaboration fails otherwise.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  cluster mode (same encoding as cfg[1:0]): 00 single, 01 dual, 10 quad, 11 reserved.
- capture  in  1  single-cycle request to snapshot out0..out3.
- out0, out1, out2, out3  in  ACC_WIDTH each  cluster result words.
- tx_data  out  OUT_WIDTH  current beat.
- tx_valid  out  1  beat valid.
- tx_ready  in  1  downstream accept.
- tx_last  out  1  final beat of the snapshot; qualified by tx_valid.
- busy  out  1  a snapshot is pending or being sent.
- overrun  out  1  sticky: a capture was dropped.
- clr_overrun  in  1  clears overrun.

Behaviour:
- Reset: one clock, synchronous, active-high; rst has priority over every other input.
  - On reset: tx_valid=0, tx_last=0, tx_data=0, busy=0, overrun=0; state IDLE; counters 0; snapshot registers 0.
- Word count W is set by mode:
  - 00 → 4 words (out0, out1, out2, out3).
  - 01 → 2 words (out0, out1).
  - 10 → 1 word (out0).
  - 11 → treated as 00.
- Beats per word: BPW = ACC_WIDTH/OUT_WIDTH.
- Total beats: W*BPW.
- The mode value is sampled together with the data at capture. Later changes to mode do not affect a snapshot in flight.
- Handshake: a beat transfers on a cycle where tx_valid && tx_ready.
  - While tx_valid=1 and no transfer occurs, tx_data and tx_last hold stable.
  - tx_valid never drops without a transfer, except on rst.
- Beat order: word 0 first, then ascending word index. Within a word, least-significant OUT_WIDTH slice first.
- FSM:
  - IDLE:
    - On capture: latch out0..out3 and W, zero the beat/word counters, go to SEND.
    - tx_valid=1 from the next cycle. Latency is capture at cycle N → first beat valid at N+1.
  - SEND:
    - tx_valid=1.
    - On each transfer, advance the beat counter. On wrap at BPW-1, advance the word counter.
    - tx_last=1 when word=W-1 and beat=BPW-1.
    - On the transfer of the last beat:
      - If capture is also asserted that cycle, perform a fresh snapshot and stay in SEND. tx_valid stays 1 and the first new beat is presented at the next cycle. This is back-to-back operation with no bubble.
      - Otherwise go to IDLE and drop tx_valid.
- busy=1 in SEND. busy=0 in IDLE.
- Capture in SEND on any cycle other than a last-beat transfer:
  - The capture is ignored and the snapshot is unchanged.
  - overrun is set to 1 the next cycle.
- Overrun clearing:
  - clr_overrun clears overrun.
  - If a dropped capture and clr_overrun occur in the same cycle, set wins (overrun=1).
- Reset mid-transfer aborts the snapshot immediately. No partial tx_last is emitted.
- tx_data is 0 whenever tx_valid=0.

Decomposition:
- The shared header mac_const.vh gets:
  - `MAC_MODE_SINGLE, `MAC_MODE_DUAL, `MAC_MODE_QUAD encodings (2 bits, matching the combiner's cfg[1:0]).
  - `MAC_DRAIN_OUT_WIDTH default.
- One sub-module is natural: mac_drain_slicer, a combinational mux that selects snapshot word[word_cnt] slice[beat_cnt] into tx_data.
- The FSM, counters and snapshot registers stay in mac_result_drain.

Test Plan:
- All tests use ACC_WIDTH=32 and OUT_WIDTH=16.
1. Single mode, tx_ready tied high.
   - Stimulus: mode=00; out0..out3 = 32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888; capture pulse at cycle 10.
   - Required: beats 2222, 1111, 4444, 3333, 6666, 5555, 8888, 7777 on cycles 11-18; tx_last only at cycle 18; busy low at cycle 19.
2. Quad mode.
   - Stimulus: mode=10; out0=32'hDEADBEEF.
   - Required: exactly 2 beats, BEEF then DEAD (tx_last on DEAD); out1..out3 are never emitted.
3. Backpressure.
   - Stimulus: dual mode; tx_ready toggles 1,0,0,1,…; out0..out3 change every cycle after the capture.
   - Required: 4 beats carry the values from the capture cycle; data is stable during stalls.
4. Overrun.
   - Stimulus: capture during beat 2 of a single-mode transfer.
   - Required: the stream is unchanged; overrun=1 next cycle.
   - Then clr_overrun together with another dropped capture: overrun stays 1.
   - Then clr_overrun alone: overrun returns to 0.
5. Back-to-back.
   - Stimulus: capture on the cycle the last beat transfers.
   - Required: tx_valid never deasserts; the next beat is slice 0 of the new out0.
6. Reset mid-stream.
   - Stimulus: rst at beat 3.
   - Required: next cycle tx_valid=0, busy=0, overrun=0, tx_data=0.
   - A subsequent capture restarts at word 0, slice 0.
